// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : constants and types shared by the RV32I ALU and the branch unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int XLEN = 32;

   localparam logic OP_SUMA  = 1'b0;
   localparam logic OP_RESTA = 1'b1;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/fn_suma_resta_if.sv
// ============================================================================
// fn_suma_resta_if : operand/result bundle of the adder/subtractor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface fn_suma_resta_if
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             resta;
   logic             valid_in;
   logic [WIDTH-1:0] Y;
   logic             valid_out;
   logic             carry;
   logic             overflow;
   logic             zero;
   logic             negative;

   modport master (
      output a, b, resta, valid_in,
      input  Y, valid_out, carry, overflow, zero, negative
   );

   modport slave (
      input  a, b, resta, valid_in,
      output Y, valid_out, carry, overflow, zero, negative
   );

endinterface : fn_suma_resta_if

`default_nettype wire

// File: rtl/fn_suma_resta_sumador_cla.sv
// ============================================================================
// sumador_cla : WIDTH-bit carry-lookahead adder, 4-bit lookahead groups with
//               the group carry rippled from group to group
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sumador_cla
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   input  wire logic             cin,
   output      logic [WIDTH-1:0] s,
   output      logic             cout
);

   localparam int c_ngroups = (WIDTH + 3) / 4;
   localparam int c_pw      = c_ngroups * 4;

   // Operands are zero-padded up to a whole number of groups; cout is taken
   // at bit WIDTH so the padding never affects the result.
   logic [c_pw-1:0] w_a;
   logic [c_pw-1:0] w_b;
   logic [c_pw-1:0] w_p;
   logic [c_pw-1:0] w_g;
   logic [c_pw:0]   w_c;
   logic [c_pw-1:0] w_sum;

   assign w_a    = c_pw'(a);
   assign w_b    = c_pw'(b);
   assign w_p    = w_a ^ w_b;
   assign w_g    = w_a & w_b;
   assign w_c[0] = cin;

   for (genvar k = 0; k < c_ngroups; k++) begin : g_grp
      localparam int c_lo = 4 * k;

      assign w_c[c_lo+1] = w_g[c_lo]
                         | (w_p[c_lo] & w_c[c_lo]);
      assign w_c[c_lo+2] = w_g[c_lo+1]
                         | (w_p[c_lo+1] & w_g[c_lo])
                         | (w_p[c_lo+1] & w_p[c_lo] & w_c[c_lo]);
      assign w_c[c_lo+3] = w_g[c_lo+2]
                         | (w_p[c_lo+2] & w_g[c_lo+1])
                         | (w_p[c_lo+2] & w_p[c_lo+1] & w_g[c_lo])
                         | (w_p[c_lo+2] & w_p[c_lo+1] & w_p[c_lo] & w_c[c_lo]);
      assign w_c[c_lo+4] = w_g[c_lo+3]
                         | (w_p[c_lo+3] & w_g[c_lo+2])
                         | (w_p[c_lo+3] & w_p[c_lo+2] & w_g[c_lo+1])
                         | (w_p[c_lo+3] & w_p[c_lo+2] & w_p[c_lo+1] & w_g[c_lo])
                         | (w_p[c_lo+3] & w_p[c_lo+2] & w_p[c_lo+1] & w_p[c_lo]
                            & w_c[c_lo]);

      assign w_sum[c_lo+3:c_lo] = w_p[c_lo+3:c_lo] ^ w_c[c_lo+3:c_lo];
   end

   assign s    = w_sum[WIDTH-1:0];
   assign cout = w_c[WIDTH];

endmodule : sumador_cla

`default_nettype wire

// File: rtl/fn_suma_resta.sv
// ============================================================================
// fn_suma_resta : registered 32-bit adder/subtractor with carry/overflow/
//                 zero/negative flags, one-cycle latency
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fn_suma_resta
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input wire logic          clk,
   input wire logic          rst,
   fn_suma_resta_if.slave    bus
);

   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] w_s;
   logic             w_c;
   logic             w_ov;
   logic             w_sub;
   flags_t           w_flags;

   logic [WIDTH-1:0] r_y;
   logic             r_valid;
   flags_t           r_flags;

   // Subtraction is a + ~b + 1: invert b and feed the op bit in as carry-in.
   assign w_sub = (bus.resta == OP_RESTA);
   assign w_bx  = bus.b ^ {WIDTH{w_sub}};

   sumador_cla #(
      .WIDTH (WIDTH)
   ) u_cla (
      .a    (bus.a),
      .b    (w_bx),
      .cin  (w_sub),
      .s    (w_s),
      .cout (w_c)
   );

   assign w_ov = (bus.a[WIDTH-1] == w_bx[WIDTH-1]) && (w_s[WIDTH-1] != bus.a[WIDTH-1]);

   assign w_flags.carry    = w_c;
   assign w_flags.overflow = w_ov;
   assign w_flags.zero     = (w_s == '0);
   assign w_flags.negative = w_s[WIDTH-1];

   // Result and flags hold on idle cycles; only valid_out drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y     <= '0;
         r_valid <= 1'b0;
         r_flags <= '0;
      end else begin
         r_valid <= bus.valid_in;
         if (bus.valid_in) begin
            r_y     <= w_s;
            r_flags <= w_flags;
         end
      end
   end

   assign bus.Y         = r_y;
   assign bus.valid_out = r_valid;
   assign bus.carry     = r_flags.carry;
   assign bus.overflow  = r_flags.overflow;
   assign bus.zero      = r_flags.zero;
   assign bus.negative  = r_flags.negative;

endmodule : fn_suma_resta

`default_nettype wire

// File: tb/tb_fn_suma_resta.sv
// ============================================================================
// tb_fn_suma_resta : directed self-checking bench for fn_suma_resta
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fn_suma_resta;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   fn_suma_resta_if #(.WIDTH(WIDTH)) bus ();

   fn_suma_resta #(
      .WIDTH (WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // flags packed as {carry, overflow, zero, negative}
   function automatic logic [31:0] flags_now();
      return {28'd0, bus.carry, bus.overflow, bus.zero, bus.negative};
   endfunction

   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic resta, input logic [31:0] exp_y, input logic [3:0] exp_f);
      @(negedge clk);
      bus.a        = a;
      bus.b        = b;
      bus.resta    = resta;
      bus.valid_in = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".Y"},     bus.Y, exp_y);
      check({tag, ".flags"}, flags_now(), {28'd0, exp_f});
      check({tag, ".vout"},  {31'd0, bus.valid_out}, 32'd1);
   endtask

   task automatic idle(input string tag, input logic [31:0] exp_y, input logic [3:0] exp_f);
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h0000_0001;
      bus.resta    = ~bus.resta;
      @(posedge clk);
      #1;
      check({tag, ".Y"},     bus.Y, exp_y);
      check({tag, ".flags"}, flags_now(), {28'd0, exp_f});
      check({tag, ".vout"},  {31'd0, bus.valid_out}, 32'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst          = 1'b1;
      bus.a        = '0;
      bus.b        = '0;
      bus.resta    = OP_SUMA;
      bus.valid_in = 1'b0;

      #1;
      check("rst0.Y",     bus.Y, 32'd0);
      check("rst0.flags", flags_now(), 32'd0);
      check("rst0.vout",  {31'd0, bus.valid_out}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      op("add",     32'd15,        32'd10,        OP_SUMA,  32'd25,        4'b0000);
      op("sub",     32'd15,        32'd10,        OP_RESTA, 32'd5,         4'b1000);
      op("subneg",  32'd10,        32'd15,        OP_RESTA, 32'hFFFF_FFFB, 4'b0001);
      op("ovpos",   32'h7FFF_FFFF, 32'd1,         OP_SUMA,  32'h8000_0000, 4'b0101);
      op("wrap",    32'hFFFF_FFFF, 32'd1,         OP_SUMA,  32'h0000_0000, 4'b1010);
      op("ovneg",   32'h8000_0000, 32'd1,         OP_RESTA, 32'h7FFF_FFFF, 4'b1100);
      op("eq",      32'h1234_5678, 32'h1234_5678, OP_RESTA, 32'h0000_0000, 4'b1010);

      // back-to-back stream, then idle cycles that must hold the last result
      op("str0",    32'd1,         32'd2,         OP_SUMA,  32'd3,         4'b0000);
      op("str1",    32'd100,       32'd1,         OP_RESTA, 32'd99,        4'b1000);
      op("str2",    32'h10,        32'h20,        OP_RESTA, 32'hFFFF_FFF0, 4'b0001);
      idle("hold0",                                         32'hFFFF_FFF0, 4'b0001);
      idle("hold1",                                         32'hFFFF_FFF0, 4'b0001);

      // async reset between edges with a result sitting on the outputs
      op("pre",     32'h4000_0000, 32'h4000_0000, OP_SUMA,  32'h8000_0000, 4'b0101);
      @(negedge clk);
      bus.a        = 32'd7;
      bus.b        = 32'd8;
      bus.resta    = OP_SUMA;
      bus.valid_in = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check("arst.Y",     bus.Y, 32'd0);
      check("arst.flags", flags_now(), 32'd0);
      check("arst.vout",  {31'd0, bus.valid_out}, 32'd0);
      @(posedge clk);
      #1;
      check("arsth.Y",    bus.Y, 32'd0);
      check("arsth.vout", {31'd0, bus.valid_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
      check("post.idle",  {31'd0, bus.valid_out}, 32'd0);
      op("post",    32'd3,         32'd4,         OP_SUMA,  32'd7,         4'b0000);
      idle("postidle",                                      32'd7,         4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fn_suma_resta

`default_nettype wire

// File: doc/fn_suma_resta.md
Name: fn_suma_resta

Overview:
- 32-bit adder/subtractor for the RV32I ALU datapath; `resta` selects add (0) or subtract (1).
- Result and status flags are registered: one-cycle latency, one clock, asynchronous active-high reset.
- Feeds ADD/SUB/ADDI and compare/branch logic, which consumes the carry/overflow/zero/negative flags.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- resta  input  1  0: Y=a+b; 1: Y=a-b
- valid_in  input  1  operands valid this cycle
- Y  output  WIDTH  registered result, modulo 2^WIDTH
- valid_out  output  1  Y/flags correspond to a valid_in accepted on the previous edge
- carry  output  1  carry-out of bit WIDTH-1 of a + (b^{resta}) + resta
- overflow  output  1  signed two's-complement overflow
- zero  output  1  Y == 0
- negative  output  1  Y[WIDTH-1]

Behaviour:
- Reset: rst=1 forces Y=0, valid_out=0, carry=0, overflow=0, zero=0 and negative=0 immediately, independent of clk. Registers hold these values while rst=1.
- Reset mid-operation discards any in-flight result; the first valid_out after reset follows the first valid_in sampled with rst=0.
- Datapath (combinational, before the register):
  - bx = b XOR {WIDTH{resta}}
  - {c, s} = a + bx + resta, a (WIDTH+1)-bit sum
- Overflow: ov = (a[MSB] == bx[MSB]) && (s[MSB] != a[MSB]).
- Edge with valid_in=1: Y<=s, carry<=c, overflow<=ov, zero<=(s==0), negative<=s[MSB], valid_out<=1.
- Edge with valid_in=0: valid_out<=0; Y and all flags hold their previous values.
- Latency: exactly 1 cycle. Throughput: one operation per cycle; back-to-back valid_in is accepted every cycle with no stall and no backpressure.
- Subtract carry semantics: carry=1 means no borrow (a ≥ b unsigned). a==b gives Y=0, carry=1, zero=1.
- Wrap-around: results are modulo 2^WIDTH; no saturation.
- resta and the operands are sampled only on edges where valid_in=1; changes between edges have no effect.

Decomposition:
- Shared package `alu_pkg`:
  - constant XLEN=32, used as the WIDTH default.
  - constants OP_SUMA=1'b0 and OP_RESTA=1'b1.
  - typedef of the flags struct {carry, overflow, zero, negative}, reused by the ALU and the branch unit.
- One sub-module, `sumador_cla`: parameterised WIDTH-bit carry-lookahead adder (4-bit lookahead groups, rippled group carry) with inputs a, b, cin and outputs s, cout. fn_suma_resta instantiates it once with b=bx and cin=resta, then adds the flag logic and the output registers.

Test Plan:
- Add: a=15, b=10, resta=0, valid_in=1 -> next cycle Y=25, valid_out=1, carry=0, overflow=0, zero=0, negative=0.
- Subtract: a=15, b=10, resta=1 -> Y=5, carry=1, overflow=0, zero=0. Then a=10, b=15, resta=1 -> Y=0xFFFFFFFB, carry=0, negative=1.
- Boundaries:
  - a=0x7FFFFFFF, b=1, add -> Y=0x80000000, overflow=1, negative=1.
  - a=0xFFFFFFFF, b=1, add -> Y=0, carry=1, zero=1.
  - a=0x80000000, b=1, subtract -> Y=0x7FFFFFFF, overflow=1.
- Equality: a=b=0x12345678, subtract -> Y=0, zero=1, carry=1, overflow=0.
- Streaming and hold:
  - Three back-to-back valid ops -> three consecutive valid_out=1 cycles with matching results.
  - A following cycle with valid_in=0 -> valid_out=0, Y held at the last result.
- Async reset: assert rst between clock edges while a result is pending -> Y, all flags and valid_out go to 0 immediately. After deasserting rst, the next valid op completes normally 1 cycle later.
